// File: rtl/led_sequence_arbiter_pkg.sv
// Shared definitions for the LED sequence arbiter: color codes, FSM states
// and the color-to-LED decode used by both the arbiter and its testbench.
package led_sequence_arbiter_pkg;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_BLUE   = 2'b01;
  localparam logic [1:0] COLOR_GREEN  = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PLAY_ON  = 2'b01,
    PLAY_GAP = 2'b10,
    ECHO     = 2'b11
  } state_t;

  // LED vector bit order is {yellow, green, blue, red}
  function automatic logic [3:0] led_decode(input logic [1:0] color);
    logic [3:0] leds;
    leds = 4'b0000;
    case (color)
      COLOR_RED:    leds = 4'b0001;
      COLOR_BLUE:   leds = 4'b0010;
      COLOR_GREEN:  leds = 4'b0100;
      COLOR_YELLOW: leds = 4'b1000;
      default:      leds = 4'b0000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/led_sequence_arbiter_pattern_buffer.sv
// Pattern storage for sequence playback: an append-only color list with a
// length counter, a full flag, a synchronous clear and an async read port.
module pattern_buffer #(
  parameter int DEPTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push_valid,
  input  logic [1:0]                 push_color,
  output logic                       push_ready,
  output logic [$clog2(DEPTH):0]     length,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [1:0]                 rd_color
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  logic [1:0] mem [DEPTH];
  logic       full;
  logic       wr_en;

  assign full       = (length == LEN_W'(DEPTH));
  assign push_ready = ~full;
  assign wr_en      = push_valid & ~full & ~clear;
  assign rd_color   = mem[rd_idx];

  // Length counter: clear wins over a same-cycle push, pushes when full are dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      length <= '0;
    end else if (clear) begin
      length <= '0;
    end else if (wr_en) begin
      length <= length + LEN_W'(1);
    end
  end

  // Color storage written at the current tail; contents need no reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[length[IDX_W-1:0]] <= push_color;
    end
  end

endmodule

// File: rtl/led_sequence_arbiter.sv
// Owns the four game LEDs and shares them between CPU-driven pattern
// playback and short button-echo flashes, with hardware-timed on/gap phases.
module led_sequence_arbiter
  import led_sequence_arbiter_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ON_CYCLES   = 25000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int ECHO_CYCLES = 10000000,
  parameter int CNT_W       = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [1:0]             push_color,
  output logic                   push_ready,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   echo_valid,
  input  logic [1:0]             echo_color,
  output logic                   echo_ready,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] length,
  output logic                   red_led,
  output logic                   blue_led,
  output logic                   green_led,
  output logic                   yellow_led
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [LEN_W-1:0] play_len, play_len_n;
  logic             pending, pending_n;
  logic [1:0]       echo_col, echo_col_n;
  logic [3:0]       leds, leds_n;
  logic             done_n;
  logic [1:0]       cur_color;

  pattern_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push_valid (push_valid),
    .push_color (push_color),
    .push_ready (push_ready),
    .length     (length),
    .rd_idx     (idx),
    .rd_color   (cur_color)
  );

  assign busy       = (state != IDLE) | pending;
  assign red_led    = leds[0];
  assign blue_led   = leds[1];
  assign green_led  = leds[2];
  assign yellow_led = leds[3];

  // State, sequencing registers and the registered LED/done outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      play_len <= '0;
      pending  <= 1'b0;
      echo_col <= COLOR_RED;
      leds     <= 4'b0000;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      idx      <= idx_n;
      play_len <= play_len_n;
      pending  <= pending_n;
      echo_col <= echo_col_n;
      leds     <= leds_n;
      done     <= done_n;
    end
  end

  // Next-state logic; LEDs follow the current state one cycle later, and the timer restarts on every state entry
  always_comb begin
    state_n    = state;
    timer_n    = '0;
    idx_n      = idx;
    play_len_n = play_len;
    pending_n  = pending;
    echo_col_n = echo_col;
    done_n     = 1'b0;
    echo_ready = 1'b0;
    leds_n     = 4'b0000;

    case (state)
      PLAY_ON: leds_n = led_decode(cur_color);
      ECHO:    leds_n = led_decode(echo_col);
      default: leds_n = 4'b0000;
    endcase

    if (clear) begin
      state_n   = IDLE;
      pending_n = 1'b0;
      leds_n    = 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start || pending) begin
            pending_n = 1'b0;
            if (length == '0) begin
              done_n = 1'b1;
            end else begin
              play_len_n = length;
              idx_n      = '0;
              state_n    = PLAY_ON;
            end
          end else if (echo_valid) begin
            echo_ready = 1'b1;
            echo_col_n = echo_color;
            state_n    = ECHO;
          end
        end
        PLAY_ON: begin
          if (timer == ON_LAST) state_n = PLAY_GAP;
          else                  timer_n = timer + CNT_W'(1);
        end
        PLAY_GAP: begin
          if (timer == GAP_LAST) begin
            if ((LEN_W'(idx) + LEN_W'(1)) == play_len) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx + IDX_W'(1);
              state_n = PLAY_ON;
            end
          end else begin
            timer_n = timer + CNT_W'(1);
          end
        end
        ECHO: begin
          if (start) pending_n = 1'b1;
          if (timer == ECHO_LAST) state_n = IDLE;
          else                    timer_n = timer + CNT_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
